pb_seq_conditioner: RTL

Conditions the two raw sequence-select pushbuttons (up/down) into clean, single-cycle, mutually exclusive step pulses for the sequencer stage, which consumes them as `pb_seq_up` / `pb_seq_dn`. Each button is synchronised to `CLK_50`, debounced, edge-detected, and auto-repeated while held. Buttons are sampled raw from board pins; everything downstream sees one pulse per intended step.

---
 rtl/pb_seq_conditioner_pkg.sv | 20 ++
 rtl/pb_seq_conditioner_if.sv | 30 +++
 rtl/pb_seq_conditioner_channel.sv | 133 +++++++++++++
 rtl/pb_seq_conditioner.sv | 61 ++++++
 4 files changed

// File: rtl/pb_seq_conditioner_pkg.sv
// Shared definitions for the pushbutton sequence-select conditioner.
// Other button consumers reuse the press states and default timing constants.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } press_state_t;

  // Defaults assume a 50 MHz clock: 20 ms debounce, 0.5 s delay, 0.1 s rate
  localparam int SEQ_DEBOUNCE_CYCLES = 1_000_000;
  localparam int SEQ_REPEAT_DELAY    = 25_000_000;
  localparam int SEQ_REPEAT_RATE     = 5_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pb_seq_conditioner_if.sv
// Board-side button pins and conditioned step outputs of the conditioner.
// The slave side is the conditioner; the master side drives the pins.
interface pb_seq_conditioner_if;

  logic btn_up_raw;
  logic btn_dn_raw;
  logic pb_seq_up;
  logic pb_seq_dn;
  logic up_held;
  logic dn_held;

  modport master (
    output btn_up_raw,
    output btn_dn_raw,
    input  pb_seq_up,
    input  pb_seq_dn,
    input  up_held,
    input  dn_held
  );

  modport slave (
    input  btn_up_raw,
    input  btn_dn_raw,
    output pb_seq_up,
    output pb_seq_dn,
    output up_held,
    output dn_held
  );

endinterface

// File: rtl/pb_seq_conditioner_channel.sv
// One button channel: synchroniser, debouncer and press/auto-repeat FSM.
// Exposes the debounced level and an unmasked combinational step pulse.
module pb_channel
  import seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = SEQ_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY       = SEQ_REPEAT_DELAY,
  parameter int REPEAT_RATE        = SEQ_REPEAT_RATE,
  parameter int ACTIVE_LOW_BUTTONS = 1
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic btn_raw,
  output logic held,
  output logic pulse
);

  localparam logic RELEASED = (ACTIVE_LOW_BUTTONS != 0);
  localparam int   DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int   REP_W    = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);
  localparam logic [REP_W-1:0] REP_SAT    = {REP_W{1'b1}};

  logic             sync_meta;
  logic             sync_out;
  logic             pressed;
  logic [DB_W-1:0]  db_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic             delay_hit;
  logic             rate_hit;
  logic             cnt_clear;
  press_state_t     state;
  press_state_t     state_next;

  // Reset loads the released pin level so a held button reads as a new press
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      sync_meta <= RELEASED;
      sync_out  <= RELEASED;
    end else begin
      sync_meta <= btn_raw;
      sync_out  <= sync_meta;
    end
  end

  assign pressed = sync_out ^ RELEASED;

  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      db_cnt <= '0;
      held   <= 1'b0;
    end else if (pressed == held) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      held   <= pressed;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign delay_hit = (REPEAT_DELAY != 0) && (rep_cnt == DELAY_LAST);
  assign rate_hit  = (rep_cnt == RATE_LAST);

  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A fall always wins over a due repeat, so release never pulses
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (held) state_next = HOLD;
      HOLD: begin
        if (!held) begin
          state_next = IDLE;
        end else if (delay_hit) begin
          state_next = REPEAT;
        end
      end
      REPEAT:  if (!held) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pulse     = 1'b0;
    cnt_clear = 1'b0;
    case (state)
      IDLE: begin
        if (held) begin
          pulse     = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      HOLD: begin
        if (held && delay_hit) begin
          pulse     = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      REPEAT: begin
        if (held && rate_hit) begin
          pulse     = 1'b1;
          cnt_clear = 1'b1;
        end
      end
      default: begin
        pulse     = 1'b0;
        cnt_clear = 1'b0;
      end
    endcase
  end

  // With repeat disabled the counter parks at all-ones while held
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      rep_cnt <= '0;
    end else if (cnt_clear || (state == IDLE)) begin
      rep_cnt <= '0;
    end else if (rep_cnt != REP_SAT) begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pb_seq_conditioner.sv
// Conditions the up/down sequence-select buttons into registered,
// mutually exclusive single-cycle step pulses for the sequencer.
module pb_seq_conditioner
  import seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = SEQ_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY       = SEQ_REPEAT_DELAY,
  parameter int REPEAT_RATE        = SEQ_REPEAT_RATE,
  parameter int ACTIVE_LOW_BUTTONS = 1
) (
  input  logic                  CLK_50,
  input  logic                  reset,
  pb_seq_conditioner_if.slave   bus
);

  logic up_level;
  logic up_pulse;
  logic dn_level;
  logic dn_pulse;

  pb_channel #(
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .REPEAT_DELAY      (REPEAT_DELAY),
    .REPEAT_RATE       (REPEAT_RATE),
    .ACTIVE_LOW_BUTTONS(ACTIVE_LOW_BUTTONS)
  ) u_up (
    .CLK_50 (CLK_50),
    .reset  (reset),
    .btn_raw(bus.btn_up_raw),
    .held   (up_level),
    .pulse  (up_pulse)
  );

  pb_channel #(
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .REPEAT_DELAY      (REPEAT_DELAY),
    .REPEAT_RATE       (REPEAT_RATE),
    .ACTIVE_LOW_BUTTONS(ACTIVE_LOW_BUTTONS)
  ) u_dn (
    .CLK_50 (CLK_50),
    .reset  (reset),
    .btn_raw(bus.btn_dn_raw),
    .held   (dn_level),
    .pulse  (dn_pulse)
  );

  // Holding the opposite button silences a channel without stalling its FSM
  always_ff @(posedge CLK_50 or negedge reset) begin
    if (!reset) begin
      bus.pb_seq_up <= 1'b0;
      bus.pb_seq_dn <= 1'b0;
    end else begin
      bus.pb_seq_up <= up_pulse & ~dn_level;
      bus.pb_seq_dn <= dn_pulse & ~up_level;
    end
  end

  assign bus.up_held = up_level;
  assign bus.dn_held = dn_level;

endmodule
